// File: rtl/fc_obuf.sv
// fc_obuf: bit-serial partial-sum accumulator with saturating requantised drain
module fc_obuf #(
  parameter int DATA_SIZE      = 8,
  parameter int XBAR_SIZE      = 128,
  parameter int OBUF_BUS_WIDTH = 46,
  parameter int PSUM_SIZE      = DATA_SIZE + $clog2(XBAR_SIZE),
  parameter int OBUF_DATA_SIZE = 2*DATA_SIZE + $clog2(XBAR_SIZE),
  parameter int NUM_CHANNELS   = OBUF_BUS_WIDTH / OBUF_DATA_SIZE,
  parameter int FIFO_LENGTH    = ((XBAR_SIZE/DATA_SIZE) + NUM_CHANNELS - 1) / NUM_CHANNELS,
  parameter int OUT_SHIFT      = DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_psum_valid,
  output logic                 o_psum_ready,
  input  logic [PSUM_SIZE-1:0] i_psum [NUM_CHANNELS],
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATA_SIZE-1:0] o_data [NUM_CHANNELS],
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int BW = FIFO_LENGTH > 1 ? $clog2(FIFO_LENGTH) : 1;
  localparam int PW = DATA_SIZE > 1 ? $clog2(DATA_SIZE) : 1;
  localparam logic [OBUF_DATA_SIZE-1:0] MAXV = OBUF_DATA_SIZE'((64'd1 << DATA_SIZE) - 64'd1);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  state_t state, state_nx;
  logic [BW-1:0] beat, idx;
  logic [PW-1:0] plane;
  logic [OBUF_DATA_SIZE-1:0] acc [FIFO_LENGTH][NUM_CHANNELS];
  logic in_xfer, out_xfer, last_beat, last_plane, last_idx;
  assign o_psum_ready = state == ACCUM;
  assign o_valid      = state == DRAIN;
  assign o_busy       = state != IDLE;
  assign in_xfer      = i_psum_valid && o_psum_ready;
  assign out_xfer     = o_valid && i_ready;
  assign last_beat    = beat == BW'(FIFO_LENGTH - 1);
  assign last_plane   = plane == PW'(DATA_SIZE - 1);
  assign last_idx     = idx == BW'(FIFO_LENGTH - 1);
  // next state: start only from idle, drain after the last beat of the last plane
  always_comb begin
    state_nx = (state == IDLE && i_start) ? ACCUM :
               (in_xfer && last_beat && last_plane) ? DRAIN :
               (out_xfer && last_idx) ? IDLE : state;
  end
  // state, beat/plane/drain counters and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      beat   <= '0;
      plane  <= '0;
      idx    <= '0;
      o_done <= 1'b0;
    end else begin
      state  <= state_nx;
      o_done <= out_xfer && last_idx;
      if (in_xfer) beat <= last_beat ? '0 : beat + 1'b1;
      if (in_xfer && last_beat) plane <= last_plane ? '0 : plane + 1'b1;
      if (out_xfer) idx <= last_idx ? '0 : idx + 1'b1;
    end
  end
  // plane 0 overwrites, later planes add the bit-weighted partial sum
  always_ff @(posedge clk) begin
    if (in_xfer && !rst)
      for (int c = 0; c < NUM_CHANNELS; c++)
        acc[beat][c] <= (plane == '0) ? OBUF_DATA_SIZE'(i_psum[c])
                        : acc[beat][c] + (OBUF_DATA_SIZE'(i_psum[c]) << plane);
  end
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_out
    logic [OBUF_DATA_SIZE-1:0] q;
    assign q         = acc[idx][c] >> OUT_SHIFT;
    assign o_data[c] = !o_valid ? '0 : (q > MAXV) ? '1 : q[DATA_SIZE-1:0];
  end
endmodule

// File: tb/tb_fc_obuf.sv
// tb_fc_obuf: randomized scoreboard bench for fc_obuf against a plane-sum model
module tb_fc_obuf;
  localparam int DS = 8, NC = 2, FL = 8;
  logic clk = 0, rst = 1, i_start = 0, i_psum_valid = 0, i_ready = 1;
  logic o_psum_ready, o_valid, o_busy, o_done;
  logic [14:0] i_psum [NC];
  logic [7:0] o_data [NC];
  fc_obuf dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_psum_valid(i_psum_valid),
    .o_psum_ready(o_psum_ready), .i_psum(i_psum), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_busy(o_busy), .o_done(o_done)
  );
  always #5 clk = ~clk;
  int chk = 0, pass = 0, done_cnt = 0, jobs = 0, seen = 0, stall_left = 0;
  bit stall_en = 0, rnd_ready = 0, gaps = 0, extra_start = 0;
  logic [15:0] q [$];
  int ps [DS][FL][NC];
  task automatic check(input string name, input longint got, input longint exp);
    chk++;
    if (got == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask
  // monitor: compare every presented output beat against the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (o_done) done_cnt++;
      if (o_valid) begin
        if (q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          check("o_data0", o_data[0], q[0][7:0]);
          check("o_data1", o_data[1], q[0][15:8]);
          if (i_ready) begin
            void'(q.pop_front());
            seen++;
          end
        end
      end else begin
        check("idle_data0", o_data[0], 0);
        check("idle_data1", o_data[1], 0);
      end
    end
  end
  // downstream ready: optional 5-cycle stall at drain beat 3, optional random backpressure
  initial forever begin
    @(posedge clk); #1;
    if (stall_en && o_valid && seen == 3 && stall_left > 0) begin
      i_ready = 0;
      stall_left--;
    end else i_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic fill(input int mode, input int v);
    for (int p = 0; p < DS; p++)
      for (int b = 0; b < FL; b++)
        for (int c = 0; c < NC; c++)
          if (mode != 3) ps[p][b][c] = mode == 0 ? v : mode == 1 ? int'($urandom_range(0, 32767)) : (p == DS-1 ? v : 0);
  endtask
  task automatic start_job();
    seen = 0;
    i_start = 1;
    @(posedge clk); #1;
    i_start = 0;
  endtask
  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      int p, b, t;
      p = k / FL;
      b = k % FL;
      t = 0;
      while (gaps && $urandom_range(0, 2) == 0) begin
        i_psum_valid = 0;
        i_start = extra_start && ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
      end
      i_start = 0;
      i_psum_valid = 1;
      for (int c = 0; c < NC; c++) i_psum[c] = 15'(ps[p][b][c]);
      @(negedge clk);
      while (!o_psum_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) check("psum_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    i_psum_valid = 0;
  endtask
  task automatic push_expected();
    for (int b = 0; b < FL; b++) begin
      logic [15:0] e;
      for (int c = 0; c < NC; c++) begin
        longint s;
        s = 0;
        for (int p = 0; p < DS; p++) s += longint'(ps[p][b][c]) * (longint'(1) << p);
        s = s / 256;
        if (s > 255) s = 255;
        e[c*8 +: 8] = 8'(s);
      end
      q.push_back(e);
    end
  endtask
  task automatic run_job(input int mode, input int v);
    int t;
    fill(mode, v);
    start_job();
    feed(DS * FL);
    push_expected();
    check("first_valid", o_valid, 1);
    check("ready_low_in_drain", o_psum_ready, 0);
    jobs++;
    t = 0;
    while ((q.size() > 0 || o_busy) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) check("drain_timeout", 0, 1);
    @(negedge clk);
    @(posedge clk); #1;
    check("done_count", done_cnt, jobs);
    check("done_one_cycle", o_done, 0);
    check("busy_after_job", o_busy, 0);
  endtask
  initial begin
    for (int c = 0; c < NC; c++) i_psum[c] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_psum_ready, 0);
    check("rst_done", o_done, 0);
    rst = 0;
    @(posedge clk); #1;
    run_job(0, 256);
    run_job(0, 4);
    run_job(0, 32767);
    run_job(1, 0);
    run_job(2, 2);
    stall_en = 1;
    stall_left = 5;
    run_job(1, 0);
    check("stall_cycles_left", stall_left, 0);
    stall_en = 0;
    fill(1, 0);
    start_job();
    feed(3 * FL + 3);
    i_psum_valid = 1;
    i_start = 1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    i_start = 0;
    i_psum_valid = 0;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_ready", o_psum_ready, 0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_done", o_done, 0);
    check("mid_rst_data0", o_data[0], 0);
    check("mid_rst_data1", o_data[1], 0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt, jobs);
    run_job(1, 0);
    run_job(1, 0);
    gaps = 1;
    extra_start = 1;
    rnd_ready = 1;
    run_job(3, 0);
    for (int i = 0; i < 3; i++) run_job(1, 0);
    gaps = 0;
    extra_start = 0;
    rnd_ready = 0;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule

// File: doc/fc_obuf.md
FC_OBUF -- requirements
Module: fc_obuf

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, activation/weight bit width and number of bit-planes per job.
REQ-002 SHALL have parameter XBAR_SIZE, default 128, crossbar rows and columns.
REQ-003 SHALL have parameter OBUF_BUS_WIDTH, default 46, partial-sum bus width.
REQ-004 SHALL have parameter PSUM_SIZE, default DATA_SIZE+$clog2(XBAR_SIZE), width of one per-plane partial sum.
REQ-005 SHALL have parameter OBUF_DATA_SIZE, default 2*DATA_SIZE+$clog2(XBAR_SIZE), accumulator width.
REQ-006 SHALL have parameter NUM_CHANNELS, default floor(OBUF_BUS_WIDTH/OBUF_DATA_SIZE), values per beat.
REQ-007 SHALL have parameter FIFO_LENGTH, default ceil(floor(XBAR_SIZE/DATA_SIZE)/NUM_CHANNELS), beats per plane.
REQ-008 SHALL have parameter OUT_SHIFT, default DATA_SIZE, requantisation right-shift.
REQ-009 SHALL have port clk, input, 1, sole clock; one clock; reset is synchronous and active-high.
REQ-010 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-011 SHALL have port i_start, input, 1, begin job.
REQ-012 SHALL have port i_psum_valid, input, 1, partial-sum beat valid.
REQ-013 SHALL have port o_psum_ready, output, 1, beat accepted when high with i_psum_valid.
REQ-014 SHALL have port i_psum, input, NUM_CHANNELS x PSUM_SIZE (unpacked array), unsigned partial sums.
REQ-015 SHALL have port o_valid, output, 1, output beat valid.
REQ-016 SHALL have port i_ready, input, 1, downstream fc_ibuf write accept.
REQ-017 SHALL have port o_data, output, NUM_CHANNELS x DATA_SIZE (unpacked array), requantised results.
REQ-018 SHALL have port o_busy, output, 1, high while not IDLE.
REQ-019 SHALL have port o_done, output, 1, one-cycle job-complete pulse.

Function
REQ-020 SHALL implement FSM IDLE -> ACCUM on i_start; ACCUM -> DRAIN after final beat of plane DATA_SIZE-1; DRAIN -> IDLE after final output handshake.
REQ-021 SHALL ignore i_start outside IDLE.
REQ-022 SHALL hold o_psum_ready = 1 only in ACCUM; input transfer = i_psum_valid & o_psum_ready; gaps in i_psum_valid stall counters.
REQ-023 SHALL keep beat counter 0..FIFO_LENGTH-1 and plane counter 0..DATA_SIZE-1; beat wraps to 0 and plane increments on each plane's last beat.
REQ-024 SHALL on transfer at plane p, beat b, channel c: plane 0 acc[b][c] = i_psum[c] (overwrite); plane p>0 acc[b][c] += i_psum[c] << p; unsigned, OBUF_DATA_SIZE bits, no overflow possible.
REQ-025 SHALL assert o_valid in every DRAIN cycle; first valid in the cycle after the final input transfer.
REQ-026 SHALL drive o_data[c] = min(acc[d][c] >> OUT_SHIFT, 2^DATA_SIZE-1) for drain index d, issued 0..FIFO_LENGTH-1.
REQ-027 SHALL advance d only on o_valid & i_ready; o_data held stable while i_ready low.
REQ-028 SHALL pulse o_done for one cycle, the cycle after the final drain handshake, with state already IDLE.
REQ-029 SHALL drive o_data to 0 when o_valid is low.

Reset
REQ-030 SHALL on rst (any state, including mid-ACCUM/DRAIN) go to IDLE next edge: counters 0, o_psum_ready 0, o_valid 0, o_done 0, o_busy 0, o_data 0; accumulator contents not reset.
REQ-031 SHALL give rst priority over i_start and all handshakes in the same cycle.

Verification
REQ-032 SHALL verify: defaults (PSUM 15, ACC 23, 2 ch, 8 beats), all psum=256 all 8 planes -> 8 beats of o_data {255,255}, o_done once.
REQ-033 SHALL verify: all psum=4 all planes -> o_data {3,3}; psum=32767 all planes -> acc 8355585, saturated {255,255}.
REQ-034 SHALL verify: back-to-back jobs; job 2 psum=2 on plane 7 only, 0 elsewhere -> {1,1}, no residue from job 1.
REQ-035 SHALL verify: i_ready low 5 cycles at drain beat 3 -> o_valid high, o_data constant, no beat skipped or duplicated.
REQ-036 SHALL verify: rst at plane 3 -> IDLE next cycle, all outputs 0; following job yields correct results.
REQ-037 SHALL verify: random i_psum_valid gaps and i_start while busy -> results identical to gap-free run, extra start ignored.
